// File: rtl/bus_timer.sv
// -----------------------------------------------------------------------------
// bus_timer
//   Memory-mapped 16-bit down-counting timer on the CPU data bus. It has a
//   programmable prescaler, one-shot or auto-reload modes, and a sticky pending
//   flag that software clears. It drives irq_timer, which feeds bit 0 of the
//   CPU irq vector.
//
//   Optional feature macro: TIMER_PWM_EN
//     Defining it adds the CMP register (offset 5) and the pwm_out port.
//     Without it, offset 5 reads 0 and writes to it are ignored.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sel        bus decoder select for this block
//   we         write strobe; a write happens when sel & we on a clk edge
//   addr[2:0]  register offset
//   wdata      write data (CPU_WIDTH)
//   rdata      combinational read data; 0 when sel=0
//   irq_timer  level interrupt = PEND & IE
//   pwm_out    registered PWM output (TIMER_PWM_EN only)
//
// Register map (unlisted bits read 0)
//   0 CTRL   [0]EN [1]AR [2]IE
//   1 LOAD   reload value
//   2 COUNT  live counter; a write loads it directly
//   3 PRESC  prescaler; one tick every PRESC+1 cycles while EN=1
//   4 STATUS [0]PEND; writing 1 clears it, writing 0 does nothing
//   5 CMP    PWM compare value (TIMER_PWM_EN only)
//
// Bus handshake: there is no ready. The block accepts a write on every
// clk edge where sel & we is high. rdata is valid in the same cycle that sel
// is high.
// -----------------------------------------------------------------------------
module bus_timer #(
  parameter int CPU_WIDTH   = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sel,
  input  logic                 we,
  input  logic [2:0]           addr,
  input  logic [CPU_WIDTH-1:0] wdata,
  output logic [CPU_WIDTH-1:0] rdata,
  output logic                 irq_timer
`ifdef TIMER_PWM_EN
  ,
  output logic                 pwm_out
`endif
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_LOAD   = 3'd1;
  localparam logic [2:0] A_COUNT  = 3'd2;
  localparam logic [2:0] A_PRESC  = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
`ifdef TIMER_PWM_EN
  localparam logic [2:0] A_CMP    = 3'd5;
`endif

  localparam logic [CPU_WIDTH-1:0]   CNT_ONE  = {{(CPU_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESC_WIDTH-1:0] PCNT_ONE = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

  logic                   en_q, en_d;
  logic                   ar_q, ar_d;
  logic                   ie_q, ie_d;
  logic                   pend_q, pend_d;
  logic [CPU_WIDTH-1:0]   load_q, load_d;
  logic [CPU_WIDTH-1:0]   count_q, count_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
`ifdef TIMER_PWM_EN
  logic [CPU_WIDTH-1:0]   cmp_q, cmp_d;
  logic                   pwm_q;
`endif

  logic wr, wr_ctrl, wr_load, wr_count, wr_presc, wr_status;
  logic tick, expire;

  assign wr        = sel & we;
  assign wr_ctrl   = wr & (addr == A_CTRL);
  assign wr_load   = wr & (addr == A_LOAD);
  assign wr_count  = wr & (addr == A_COUNT);
  assign wr_presc  = wr & (addr == A_PRESC);
  assign wr_status = wr & (addr == A_STATUS);

  assign tick   = en_q & (pcnt_q == presc_q);
  assign expire = tick & (count_q == '0);

  // Next-state logic. Timer progress is applied first, then bus writes
  // override it. That gives "write wins" for COUNT and CTRL.EN. The PEND
  // set is applied last, so an expiry beats a simultaneous clear.
  always_comb begin
    en_d    = en_q;
    ar_d    = ar_q;
    ie_d    = ie_q;
    pend_d  = pend_q;
    load_d  = load_q;
    count_d = count_q;
    presc_d = presc_q;
    pcnt_d  = tick ? '0 : (pcnt_q + PCNT_ONE);
`ifdef TIMER_PWM_EN
    cmp_d   = cmp_q;
`endif

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_ONE;
      end else if (ar_q) begin
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end

    if (wr_ctrl) begin
      en_d = wdata[0];
      ar_d = wdata[1];
      ie_d = wdata[2];
    end
    if (wr_load)  load_d  = wdata;
    if (wr_count) count_d = wdata;
    if (wr_presc) presc_d = wdata[PRESC_WIDTH-1:0];
`ifdef TIMER_PWM_EN
    if (wr & (addr == A_CMP)) cmp_d = wdata;
`endif
    if (wr_status && wdata[0]) pend_d = 1'b0;
    if (expire)                pend_d = 1'b1;

    // The prescaler phase restarts on a PRESC write or an EN rise, and
    // stays parked at 0 whenever the timer is not running.
    if (!en_d || wr_presc || (wr_ctrl && !en_q && wdata[0])) pcnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
`ifdef TIMER_PWM_EN
      cmp_q   <= '0;
      pwm_q   <= 1'b0;
`endif
    end else begin
      en_q    <= en_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      load_q  <= load_d;
      count_q <= count_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
`ifdef TIMER_PWM_EN
      cmp_q   <= cmp_d;
      pwm_q   <= en_q & (count_q < cmp_q);
`endif
    end
  end

  // Both inputs are flops, so bus activity cannot glitch the interrupt.
  assign irq_timer = pend_q & ie_q;

`ifdef TIMER_PWM_EN
  assign pwm_out = pwm_q;
`endif

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        A_CTRL:   rdata[2:0]             = {ie_q, ar_q, en_q};
        A_LOAD:   rdata                  = load_q;
        A_COUNT:  rdata                  = count_q;
        A_PRESC:  rdata[PRESC_WIDTH-1:0] = presc_q;
        A_STATUS: rdata[0]               = pend_q;
`ifdef TIMER_PWM_EN
        A_CMP:    rdata                  = cmp_q;
`endif
        default:  rdata                  = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// -----------------------------------------------------------------------------
// tb_bus_timer
//   Self-checking bench for bus_timer. A behavioural model holds the timer's
//   architectural state and advances one clock at a time from the register
//   rules. Every cycle, the expected rdata, irq_timer and (with TIMER_PWM_EN)
//   pwm_out come from that model. Directed scenarios add fixed expectations.
//   A randomized bus phase follows them.
// -----------------------------------------------------------------------------
module tb_bus_timer;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        irq_timer;
`ifdef TIMER_PWM_EN
  logic        pwm_out;
`endif

  bus_timer #(.CPU_WIDTH(16), .PRESC_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq_timer (irq_timer)
`ifdef TIMER_PWM_EN
    ,
    .pwm_out   (pwm_out)
`endif
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- counters
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic        m_en, m_ar, m_ie, m_pend, m_pwm;
  logic [15:0] m_load, m_count, m_cmp;
  logic [7:0]  m_presc, m_pcnt;

  task automatic model_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0; m_pwm = 0;
    m_load = 0; m_count = 0; m_cmp = 0; m_presc = 0; m_pcnt = 0;
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {13'd0, m_ie, m_ar, m_en};
      3'd1: return m_load;
      3'd2: return m_count;
      3'd3: return {8'd0, m_presc};
      3'd4: return {15'd0, m_pend};
`ifdef TIMER_PWM_EN
      3'd5: return m_cmp;
`endif
      default: return 16'd0;
    endcase
  endfunction

  // True when the coming clock edge is a tick that finds COUNT at zero.
  function automatic logic model_expires_now();
    return m_en && (m_pcnt == m_presc) && (m_count == 16'd0);
  endfunction

  // Advance the model by one clock edge with the given bus inputs applied.
  task automatic model_step(input logic s, input logic w, input logic [2:0] a,
                            input logic [15:0] d);
    logic was_en;
    logic tick;
    logic expire;
    was_en = m_en;
    tick   = m_en && (m_pcnt == m_presc);
    expire = tick && (m_count == 16'd0);
`ifdef TIMER_PWM_EN
    m_pwm  = m_en && (m_count < m_cmp);
`endif
    if (m_en) m_pcnt = tick ? 8'd0 : m_pcnt + 8'd1;
    if (tick) begin
      if (m_count != 16'd0) m_count = m_count - 16'd1;
      else if (m_ar)        m_count = m_load;
      else                  m_en    = 1'b0;
    end
    if (s && w) begin
      case (a)
        3'd0: begin
          m_en = d[0]; m_ar = d[1]; m_ie = d[2];
          if (!was_en && d[0]) m_pcnt = 8'd0;
        end
        3'd1: m_load  = d;
        3'd2: m_count = d;
        3'd3: begin m_presc = d[7:0]; m_pcnt = 8'd0; end
        3'd4: if (d[0]) m_pend = 1'b0;
        3'd5: begin
`ifdef TIMER_PWM_EN
          m_cmp = d;
`endif
        end
        default: ;
      endcase
    end
    if (expire) m_pend = 1'b1;
    if (!m_en)  m_pcnt = 8'd0;
  endtask

  // ---------------------------------------------------------------- driver
  // Drive one bus cycle starting just after a rising edge. Check outputs at
  // the falling edge, then step the model on the next rising edge.
  task automatic bus_cycle(input logic s, input logic w, input logic [2:0] a,
                           input logic [15:0] d, output logic [15:0] rd);
    sel = s; we = w; addr = a; wdata = d;
    exp_q.push_back(s ? model_read(a) : 16'd0);
    @(negedge clk);
    rd = rdata;
    check("rdata", {16'd0, rdata}, {16'd0, exp_q.pop_front()});
    check("irq_timer", {31'd0, irq_timer}, {31'd0, m_pend & m_ie});
`ifdef TIMER_PWM_EN
    check("pwm_out", {31'd0, pwm_out}, {31'd0, m_pwm});
`endif
    @(posedge clk);
    model_step(s, w, a, d);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    logic [15:0] rd;
    bus_cycle(1'b1, 1'b1, a, d, rd);
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [15:0] rd);
    bus_cycle(1'b1, 1'b0, a, 16'd0, rd);
  endtask

  task automatic idle(input int n);
    logic [15:0] rd;
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 3'd0, 16'd0, rd);
  endtask

  task automatic quiesce();
    wr_reg(3'd0, 16'd0);
    wr_reg(3'd4, 16'd1);
    wr_reg(3'd2, 16'd0);
    wr_reg(3'd3, 16'd0);
    wr_reg(3'd1, 16'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [15:0] rd;
    int          first_seen, second_seen, found;

    sel = 0; we = 0; addr = 0; wdata = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state of every register.
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i), rd);
      check("reset_reg", {16'd0, rd}, 32'd0);
    end

    // Auto-reload: LOAD=3, PRESC=1 -> PEND every (3+1)*(1+1)=8 cycles.
    wr_reg(3'd1, 16'd3);
    wr_reg(3'd3, 16'd1);
    wr_reg(3'd0, 16'd7);
    first_seen = -1; second_seen = -1;
    for (int i = 0; i < 40 && second_seen < 0; i++) begin
      bus_cycle(1'b1, 1'b1, 3'd4, 16'd1, rd);
      if (rd[0]) begin
        if (first_seen < 0) first_seen = i;
        else                second_seen = i;
      end
    end
    check("ar_period", second_seen - first_seen, 32'd8);

    // Async reset while counting with an interrupt pending.
    idle(10);
    check("pre_reset_irq", {31'd0, irq_timer}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_irq", {31'd0, irq_timer}, 32'd0);
`ifdef TIMER_PWM_EN
    check("reset_pwm", {31'd0, pwm_out}, 32'd0);
`endif
    sel = 1'b1; we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      #1;
      check("reset_async_reg", {16'd0, rdata}, 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One-shot: LOAD=2, COUNT=2, PRESC=0, CTRL=EN|IE.
    wr_reg(3'd1, 16'd2);
    wr_reg(3'd2, 16'd2);
    wr_reg(3'd3, 16'd0);
    wr_reg(3'd0, 16'd5);
    idle(8);
    rd_reg(3'd0, rd); check("oneshot_ctrl", {16'd0, rd}, 32'd4);
    rd_reg(3'd2, rd); check("oneshot_count", {16'd0, rd}, 32'd0);
    rd_reg(3'd4, rd); check("oneshot_pend", {16'd0, rd}, 32'd1);
    wr_reg(3'd4, 16'd1);
    idle(8);
    rd_reg(3'd4, rd); check("oneshot_no_repend", {16'd0, rd}, 32'd0);

    // Masking and write-0-to-STATUS.
    quiesce();
    wr_reg(3'd0, 16'd1);
    idle(3);
    rd_reg(3'd4, rd); check("mask_pend", {16'd0, rd}, 32'd1);
    check("mask_irq_off", {31'd0, irq_timer}, 32'd0);
    wr_reg(3'd4, 16'd0);
    rd_reg(3'd4, rd); check("status_w0_keeps", {16'd0, rd}, 32'd1);
    wr_reg(3'd0, 16'd4);
    check("mask_irq_on", {31'd0, irq_timer}, 32'd1);

    // Clear race: STATUS clear on the exact expiry edge.
    quiesce();
    wr_reg(3'd1, 16'd3);
    wr_reg(3'd2, 16'd3);
    wr_reg(3'd0, 16'd3);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (model_expires_now()) found = 1;
      else                     idle(1);
    end
    check("race_found", found, 32'd1);
    wr_reg(3'd4, 16'd1);
    rd_reg(3'd4, rd); check("race_pend_kept", {16'd0, rd}, 32'd1);
    wr_reg(3'd0, 16'd4);
    check("race_irq_before", {31'd0, irq_timer}, 32'd1);
    wr_reg(3'd4, 16'd1);
    check("race_irq_after", {31'd0, irq_timer}, 32'd0);

`ifdef TIMER_PWM_EN
    // PWM: LOAD=9, CMP=3 -> high 3 of every 10 cycles.
    quiesce();
    wr_reg(3'd5, 16'd3);
    wr_reg(3'd1, 16'd9);
    wr_reg(3'd2, 16'd9);
    wr_reg(3'd0, 16'd3);
    idle(5);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (pwm_out) found++;
    end
    check("pwm_duty", found, 32'd6);
`else
    wr_reg(3'd5, 16'hFFFF);
    rd_reg(3'd5, rd);
    check("cmp_absent", {16'd0, rd}, 32'd0);
`endif

    // Randomized bus traffic against the model.
    quiesce();
    for (int i = 0; i < 1500; i++) begin
      logic        s, w;
      logic [2:0]  a;
      logic [15:0] d;
      s = ($urandom_range(0, 99) < 90);
      w = ($urandom_range(0, 99) < 30);
      a = 3'($urandom_range(0, 7));
      case (a)
        3'd0:    d = 16'($urandom_range(0, 7));
        3'd1:    d = 16'($urandom_range(0, 6));
        3'd2:    d = 16'($urandom_range(0, 6));
        3'd3:    d = 16'($urandom_range(0, 3));
        3'd4:    d = 16'($urandom_range(0, 1));
        default: d = 16'($urandom);
      endcase
      bus_cycle(s, w, a, d, rd);
    end

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
